rvb_clmul_arb: RTL and testbench

- Two-requester arbiter and sequencer for one shared rvb_clmul carry-less multiply unit, for example two issue slots or two harts.
- Grants the unit round-robin and tracks the owner of the single in-flight operation.
- Captures each result into a per-requester response buffer, so a back-pressured requester does not hold the unit.
- Generates the unit's synchronous active-high reset from the block's asynchronous reset.

---
 rtl/rvb_clmul_arb.sv | 134 +++++++++++++
 tb/tb_rvb_clmul_arb.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvb_clmul_arb.sv
// Two-requester round-robin arbiter in front of a single rvb_clmul unit.
// Tracks the one in-flight operation and buffers each requester's result.
module rvb_clmul_arb #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            resetn,

    input  logic            req0_din_valid,
    output logic            req0_din_ready,
    input  logic [XLEN-1:0] req0_din_rs1,
    input  logic [XLEN-1:0] req0_din_rs2,
    input  logic            req0_din_insn3,
    input  logic            req0_din_insn12,
    input  logic            req0_din_insn13,
    output logic            req0_dout_valid,
    input  logic            req0_dout_ready,
    output logic [XLEN-1:0] req0_dout_rd,

    input  logic            req1_din_valid,
    output logic            req1_din_ready,
    input  logic [XLEN-1:0] req1_din_rs1,
    input  logic [XLEN-1:0] req1_din_rs2,
    input  logic            req1_din_insn3,
    input  logic            req1_din_insn12,
    input  logic            req1_din_insn13,
    output logic            req1_dout_valid,
    input  logic            req1_dout_ready,
    output logic [XLEN-1:0] req1_dout_rd,

    output logic            cu_reset,
    output logic            cu_din_valid,
    input  logic            cu_din_ready,
    output logic [XLEN-1:0] cu_din_rs1,
    output logic [XLEN-1:0] cu_din_rs2,
    output logic            cu_din_insn3,
    output logic            cu_din_insn12,
    output logic            cu_din_insn13,
    input  logic            cu_dout_valid,
    output logic            cu_dout_ready,
    input  logic [XLEN-1:0] cu_dout_rd
);

    logic            r_inflight;
    logic            r_owner;
    logic            r_last_grant;
    logic            r_cu_reset;
    logic [1:0]      r_rbuf_valid;
    logic [XLEN-1:0] r_rbuf_data [2];

    logic [1:0]      w_req_valid;
    logic [1:0]      w_resp_ready;
    logic [1:0]      w_elig;
    logic            w_any;
    logic            w_grant;
    logic            w_issue;
    logic            w_complete;

    assign w_req_valid  = {req1_din_valid, req0_din_valid};
    assign w_resp_ready = {req1_dout_ready, req0_dout_ready};

    // A requester with a buffered result or an op in the unit must wait.
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
        assign w_elig[gi] = w_req_valid[gi] && !r_rbuf_valid[gi]
                            && !(r_inflight && (r_owner == 1'(gi)));
    end

    assign w_any = w_elig[0] || w_elig[1];

    always_comb begin
        w_grant = 1'b0;
        if (w_elig[0] && w_elig[1]) begin
            w_grant = ~r_last_grant;
        end else if (w_elig[1]) begin
            w_grant = 1'b1;
        end
    end

    assign cu_reset      = r_cu_reset;
    assign cu_din_valid  = w_any && !r_cu_reset;
    assign cu_dout_ready = r_inflight && !r_cu_reset;

    assign req0_din_ready = w_any && !w_grant && cu_din_ready && !r_cu_reset;
    assign req1_din_ready = w_any &&  w_grant && cu_din_ready && !r_cu_reset;

    assign cu_din_rs1    = w_grant ? req1_din_rs1    : req0_din_rs1;
    assign cu_din_rs2    = w_grant ? req1_din_rs2    : req0_din_rs2;
    assign cu_din_insn3  = w_grant ? req1_din_insn3  : req0_din_insn3;
    assign cu_din_insn12 = w_grant ? req1_din_insn12 : req0_din_insn12;
    assign cu_din_insn13 = w_grant ? req1_din_insn13 : req0_din_insn13;

    assign w_issue    = cu_din_valid && cu_din_ready;
    assign w_complete = cu_dout_valid && cu_dout_ready;

    assign req0_dout_valid = r_rbuf_valid[0];
    assign req1_dout_valid = r_rbuf_valid[1];
    assign req0_dout_rd    = r_rbuf_data[0];
    assign req1_dout_rd    = r_rbuf_data[1];

    // cu_reset drops only after the unit has seen one edge with it high.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cu_reset   <= 1'b1;
            r_inflight   <= 1'b0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_rbuf_valid <= 2'b00;
        end else begin
            r_cu_reset <= 1'b0;
            if (w_issue) begin
                r_inflight   <= 1'b1;
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
            end else if (w_complete) begin
                r_inflight <= 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (w_complete && (r_owner == 1'(i))) begin
                    r_rbuf_valid[i] <= 1'b1;
                end else if (r_rbuf_valid[i] && w_resp_ready[i]) begin
                    r_rbuf_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Result data needs no reset: it is only observed while its valid bit is set.
    always_ff @(posedge clock) begin
        if (w_complete) begin
            r_rbuf_data[r_owner] <= cu_dout_rd;
        end
    end

endmodule

// File: tb/tb_rvb_clmul_arb.sv
// Directed bench for rvb_clmul_arb with a small behavioural carry-less
// multiply unit attached; expected results are hand-computed constants.
module tb_rvb_clmul_arb;

    logic        clock;
    logic        resetn;

    logic        req_valid [2];
    logic [63:0] req_rs1   [2];
    logic [63:0] req_rs2   [2];
    logic [2:0]  req_insn  [2];   // {insn13, insn12, insn3}
    logic        req_dready[2];
    logic        din_ready [2];
    logic        dout_valid[2];
    logic [63:0] dout_rd   [2];

    logic        cu_reset, cu_din_valid, cu_din_ready;
    logic [63:0] cu_din_rs1, cu_din_rs2, cu_dout_rd;
    logic        cu_din_insn3, cu_din_insn12, cu_din_insn13;
    logic        cu_dout_valid, cu_dout_ready;

    rvb_clmul_arb #(.XLEN(64)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .req0_din_valid  (req_valid[0]),
        .req0_din_ready  (din_ready[0]),
        .req0_din_rs1    (req_rs1[0]),
        .req0_din_rs2    (req_rs2[0]),
        .req0_din_insn3  (req_insn[0][0]),
        .req0_din_insn12 (req_insn[0][1]),
        .req0_din_insn13 (req_insn[0][2]),
        .req0_dout_valid (dout_valid[0]),
        .req0_dout_ready (req_dready[0]),
        .req0_dout_rd    (dout_rd[0]),
        .req1_din_valid  (req_valid[1]),
        .req1_din_ready  (din_ready[1]),
        .req1_din_rs1    (req_rs1[1]),
        .req1_din_rs2    (req_rs2[1]),
        .req1_din_insn3  (req_insn[1][0]),
        .req1_din_insn12 (req_insn[1][1]),
        .req1_din_insn13 (req_insn[1][2]),
        .req1_dout_valid (dout_valid[1]),
        .req1_dout_ready (req_dready[1]),
        .req1_dout_rd    (dout_rd[1]),
        .cu_reset        (cu_reset),
        .cu_din_valid    (cu_din_valid),
        .cu_din_ready    (cu_din_ready),
        .cu_din_rs1      (cu_din_rs1),
        .cu_din_rs2      (cu_din_rs2),
        .cu_din_insn3    (cu_din_insn3),
        .cu_din_insn12   (cu_din_insn12),
        .cu_din_insn13   (cu_din_insn13),
        .cu_dout_valid   (cu_dout_valid),
        .cu_dout_ready   (cu_dout_ready),
        .cu_dout_rd      (cu_dout_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural unit ----------------
    function automatic logic [63:0] clmul(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) if (b[i]) r = r ^ (a << i);
        return r;
    endfunction

    logic        u_en, u_busy, u_tag, force_dv;
    int          u_lat, u_cnt, cyc;
    logic [63:0] u_res;
    int          cmp_cyc [2];
    logic        glog [$];
    logic [2:0]  ilog [$];

    assign cu_dout_valid = (u_busy && u_cnt == 0) || force_dv;
    assign cu_dout_rd    = force_dv ? 64'hDEAD_BEEF : u_res;
    assign cu_din_ready  = u_en && (!u_busy || (cu_dout_valid && cu_dout_ready));

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (cu_reset) begin
            u_busy <= 1'b0;
        end else begin
            if (cu_dout_valid && cu_dout_ready && !force_dv) cmp_cyc[u_tag] <= cyc + 1;
            if (cu_din_valid && cu_din_ready) begin
                u_busy <= 1'b1;
                u_cnt  <= u_lat;
                u_res  <= clmul(cu_din_rs1, cu_din_rs2);
                u_tag  <= din_ready[1];
                glog.push_back(din_ready[1]);
                ilog.push_back({cu_din_insn13, cu_din_insn12, cu_din_insn3});
            end else if (cu_dout_valid && cu_dout_ready) begin
                u_busy <= 1'b0;
            end else if (u_busy && u_cnt != 0) begin
                u_cnt <= u_cnt - 1;
            end
        end
    end

    // ---------------- requester tasks ----------------
    task automatic issue(input int n, input logic [63:0] a, input logic [63:0] b, input logic [2:0] insn);
        @(negedge clock);
        req_valid[n] = 1'b1;
        req_rs1[n]   = a;
        req_rs2[n]   = b;
        req_insn[n]  = insn;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (din_ready[n]) begin
                @(posedge clock);
                #1 req_valid[n] = 1'b0;
                return;
            end
            @(negedge clock);
        end
        chk("issue_timeout", 64'(din_ready[n]), 64'd1);
        req_valid[n] = 1'b0;
    endtask

    task automatic take(input int n, input logic [63:0] exp, input bit chk_lat, input string nm);
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (dout_valid[n]) break;
        end
        chk({nm, "_valid"}, 64'(dout_valid[n]), 64'd1);
        if (dout_valid[n]) begin
            chk(nm, dout_rd[n], exp);
            if (chk_lat) chk({nm, "_latency"}, 64'(cyc), 64'(cmp_cyc[n]));
        end
        req_dready[n] = 1'b1;
        @(posedge clock);
        #1 req_dready[n] = 1'b0;
        chk({nm, "_drained"}, 64'(dout_valid[n]), 64'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_cu_reset", 64'(cu_reset), 64'd1);
        chk("rst_cu_din_valid", 64'(cu_din_valid), 64'd0);
        chk("rst_cu_dout_ready", 64'(cu_dout_ready), 64'd0);
        chk("rst_din_ready", {din_ready[1], din_ready[0]}, 64'd0);
        chk("rst_dout_valid", {dout_valid[1], dout_valid[0]}, 64'd0);
        resetn = 1'b1;
        #1 chk("rel_cu_reset_hold", 64'(cu_reset), 64'd1);
        @(posedge clock);
        #1 chk("rel_cu_reset_drop", 64'(cu_reset), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          n;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  insn;
        logic [63:0] exp;
    } vec_t;

    vec_t vt [10];

    initial begin
        int seen;
        vt[0] = '{0, 64'h3, 64'h5, 3'b010, 64'hF};
        vt[1] = '{1, 64'h7, 64'h3, 3'b010, 64'h9};
        vt[2] = '{0, 64'hFF, 64'h1, 3'b011, 64'hFF};
        vt[3] = '{1, 64'h8000_0000_0000_0000, 64'h1, 3'b100, 64'h8000_0000_0000_0000};
        vt[4] = '{0, 64'h8000_0000_0000_0000, 64'h2, 3'b110, 64'h0};
        vt[5] = '{1, 64'h5, 64'h5, 3'b010, 64'h11};
        vt[6] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 3'b001, 64'h1};
        vt[7] = '{1, 64'hF, 64'hF, 3'b010, 64'h55};
        vt[8] = '{0, 64'h6, 64'h6, 3'b010, 64'h14};
        vt[9] = '{1, 64'h9, 64'h3, 3'b010, 64'h1B};

        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 0; req_rs1[i] = '0; req_rs2[i] = '0;
            req_insn[i] = '0; req_dready[i] = 0;
        end
        u_en = 1; u_busy = 0; u_tag = 0; u_lat = 0; u_cnt = 0; u_res = '0;
        force_dv = 0; cyc = 0; cmp_cyc[0] = 0; cmp_cyc[1] = 0;
        resetn = 0;

        // requester valid during reset must not reach the unit
        req_valid[0] = 1;
        #12 chk("rst_req_blocked", 64'(din_ready[0]), 64'd0);
        req_valid[0] = 0;
        do_reset();

        // single CLMUL op
        issue(0, 64'h3, 64'h5, 3'b010);
        chk("single_grant", 64'(glog[$]), 64'd0);
        chk("single_insn", 64'(ilog[$]), 64'b010);
        chk("single_r1_quiet", 64'(dout_valid[1]), 64'd0);
        take(0, 64'hF, 1, "single_rd");
        chk("single_r1_none", 64'(dout_valid[1]), 64'd0);

        // table: sequential ops, varying unit latency
        for (int i = 0; i < 10; i++) begin
            u_lat = i % 3;
            issue(vt[i].n, vt[i].a, vt[i].b, vt[i].insn);
            chk($sformatf("vec%0d_grant", i), 64'(glog[$]), 64'(vt[i].n));
            chk($sformatf("vec%0d_insn", i), 64'(ilog[$]), 64'(vt[i].insn));
            take(vt[i].n, vt[i].exp, 1, $sformatf("vec%0d_rd", i));
            chk($sformatf("vec%0d_other", i), 64'(dout_valid[1 - vt[i].n]), 64'd0);
        end

        // stray unit result while nothing is in flight
        @(negedge clock);
        force_dv = 1;
        #1 chk("stray_dout_ready", 64'(cu_dout_ready), 64'd0);
        @(posedge clock);
        #1 force_dv = 0;
        chk("stray_no_resp", {dout_valid[1], dout_valid[0]}, 64'd0);

        // contention right after reset, overlapping completion and issue
        do_reset();
        u_lat = 0;
        @(negedge clock);
        req_valid[0] = 1; req_rs1[0] = 64'h7; req_rs2[0] = 64'h3; req_insn[0] = 3'b010;
        req_valid[1] = 1; req_rs1[1] = 64'h5; req_rs2[1] = 64'h5; req_insn[1] = 3'b010;
        #1 chk("cont_grant0", {din_ready[1], din_ready[0]}, 64'b01);
        @(posedge clock);
        #1 req_valid[0] = 0;
        @(negedge clock);
        chk("cont_grant1", {din_ready[1], din_ready[0]}, 64'b10);
        chk("cont_inflight", 64'(cu_dout_ready), 64'd1);
        @(posedge clock);
        #1 req_valid[1] = 0;
        chk("ovl_r0_valid", 64'(dout_valid[0]), 64'd1);
        chk("ovl_r0_rd", dout_rd[0], 64'h9);
        chk("ovl_still_inflight", 64'(cu_dout_ready), 64'd1);
        chk("ovl_r1_pending", 64'(dout_valid[1]), 64'd0);
        @(posedge clock);
        #1 chk("cont_r1_rd", dout_rd[1], 64'h11);
        chk("cont_r1_valid", 64'(dout_valid[1]), 64'd1);
        chk("cont_r0_kept", dout_rd[0], 64'h9);
        req_dready[0] = 1; req_dready[1] = 1;
        @(posedge clock);
        #1 req_dready[0] = 0; req_dready[1] = 0;

        // fairness: both requesters continuously busy
        u_lat = 2;
        glog.delete();
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    issue(0, vt[2*k].a, vt[2*k].b, vt[2*k].insn);
                    take(0, vt[2*k].exp, 0, $sformatf("fair_r0_op%0d", k));
                end
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    issue(1, vt[2*k+1].a, vt[2*k+1].b, vt[2*k+1].insn);
                    take(1, vt[2*k+1].exp, 0, $sformatf("fair_r1_op%0d", k));
                end
            end
        join
        chk("fair_count", 64'(glog.size()), 64'd8);
        for (int i = 0; i < glog.size(); i++)
            chk($sformatf("fair_order%0d", i), 64'(glog[i]), 64'(i % 2));

        // back-pressure on requester 0
        u_lat = 1;
        glog.delete();
        issue(0, 64'hF, 64'hF, 3'b010);
        for (int t = 0; t < 50 && !dout_valid[0]; t++) @(negedge clock);
        @(negedge clock);
        req_valid[0] = 1; req_rs1[0] = 64'h9; req_rs2[0] = 64'h3; req_insn[0] = 3'b010;
        issue(1, 64'h6, 64'h6, 3'b010);
        take(1, 64'h14, 0, "bp_r1_a");
        issue(1, 64'hFF, 64'h1, 3'b010);
        take(1, 64'hFF, 0, "bp_r1_b");
        chk("bp_grants", 64'(glog.size()), 64'd3);
        chk("bp_grant_a", 64'(glog[1]), 64'd1);
        chk("bp_grant_b", 64'(glog[2]), 64'd1);
        chk("bp_r0_held", 64'(dout_valid[0]), 64'd1);
        take(0, 64'h55, 0, "bp_r0_first");
        issue(0, 64'h9, 64'h3, 3'b010);
        chk("bp_r0_regrant", 64'(glog[$]), 64'd0);
        take(0, 64'h1B, 0, "bp_r0_second");

        // reset in the middle of an operation
        u_lat = 3;
        issue(0, 64'h3, 64'h5, 3'b010);
        @(negedge clock);
        req_valid[1] = 1; req_rs1[1] = 64'h5; req_rs2[1] = 64'h5;
        #2 resetn = 0;
        #1 chk("mid_cu_reset", 64'(cu_reset), 64'd1);
        chk("mid_cu_din_valid", 64'(cu_din_valid), 64'd0);
        chk("mid_cu_dout_ready", 64'(cu_dout_ready), 64'd0);
        chk("mid_din_ready", {din_ready[1], din_ready[0]}, 64'd0);
        req_valid[1] = 0;
        do_reset();
        seen = 0;
        repeat (10) begin
            @(negedge clock);
            if (dout_valid[0] || dout_valid[1]) seen++;
        end
        chk("mid_no_stale", 64'(seen), 64'd0);
        issue(1, 64'h5, 64'h5, 3'b010);
        take(1, 64'h11, 1, "post_rst_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
